// File: rtl/pecas_pkg.sv
// Shared definitions for the piece-placement validator: piece type encodings,
// piece lengths, board default size and the validator FSM state encoding.
package pecas_pkg;

    // Default board side; coordinates run 1..N_LADO, 0 means "no switch selected".
    localparam int N_LADO_PADRAO = 8;

    // Longest piece in the fleet (porta-avioes).
    localparam int COMPR_MAX = 5;

    // Count register saturation value.
    localparam logic [4:0] CONTAGEM_MAX = 5'd31;

    typedef enum logic [2:0] {
        SUBMARINO    = 3'd0,
        CRUZADOR     = 3'd1,
        HIDROAVIAO   = 3'd2,
        ENCOURACADO  = 3'd3,
        PORTA_AVIOES = 3'd4
    } tipo_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESULT = 2'd2,
        WRITE  = 2'd3
    } estado_t;

    // Number of cells of a piece; 0 flags an illegal type code.
    function automatic logic [2:0] comprimento(input logic [2:0] tipo);
        case (tipo)
            SUBMARINO:    return 3'd1;
            CRUZADOR:     return 3'd2;
            HIDROAVIAO:   return 3'd3;
            ENCOURACADO:  return 3'd4;
            PORTA_AVIOES: return 3'd5;
            default:      return 3'd0;
        endcase
    endfunction

    // Saturating increment for the per-player cell counters.
    function automatic logic [4:0] incr_sat(input logic [4:0] valor);
        return (valor == CONTAGEM_MAX) ? valor : valor + 5'd1;
    endfunction

endpackage

// File: rtl/gerador_celulas.sv
// Combinational cell generator: for piece cell k, returns the (dx, dy) offset
// from the piece origin, the piece length and whether the type code is legal.
// Shared by the CHECK and WRITE phases of the validator.
module gerador_celulas
    import pecas_pkg::*;
(
    input  logic [2:0] tipo,
    input  logic       direcao,
    input  logic [2:0] orientacao,
    input  logic [2:0] k,
    output logic [2:0] dx,
    output logic [2:0] dy,
    output logic [2:0] len,
    output logic       tipo_valido
);

    logic [1:0] forma;

    // Hidroaviao shape select: codes above 3 fall back to shape 0.
    assign forma = (orientacao > 3'd3) ? 2'd0 : orientacao[1:0];

    // Offset lookup for cell k of the current piece.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        dx          = 3'd0;
        dy          = 3'd0;
        len         = comprimento(tipo);
        tipo_valido = (len != 3'd0);

        if (tipo == HIDROAVIAO) begin
            case (forma)
                2'd0: case (k)
                    3'd1:    begin dx = 3'd1; dy = 3'd1; end
                    3'd2:    begin dx = 3'd2; dy = 3'd0; end
                    default: begin dx = 3'd0; dy = 3'd0; end
                endcase
                2'd1: case (k)
                    3'd1:    begin dx = 3'd1; dy = 3'd0; end
                    3'd2:    begin dx = 3'd2; dy = 3'd1; end
                    default: begin dx = 3'd0; dy = 3'd1; end
                endcase
                2'd2: case (k)
                    3'd1:    begin dx = 3'd1; dy = 3'd1; end
                    3'd2:    begin dx = 3'd0; dy = 3'd2; end
                    default: begin dx = 3'd0; dy = 3'd0; end
                endcase
                default: case (k)
                    3'd1:    begin dx = 3'd0; dy = 3'd1; end
                    3'd2:    begin dx = 3'd1; dy = 3'd2; end
                    default: begin dx = 3'd1; dy = 3'd0; end
                endcase
            endcase
        end else if (direcao) begin
            dy = k;
        end else begin
            dx = k;
        end
    end

endmodule

// File: rtl/validador_pecas.sv
// Piece validator: holds both players' occupancy boards, checks a proposed
// piece one cell per cycle for out-of-board and overlap, and commits it when
// the placement FSM drops valida after a conflict-free check.
module validador_pecas
    import pecas_pkg::*;
#(
    parameter int N_LADO = N_LADO_PADRAO,
    parameter int N_CEL  = N_LADO * N_LADO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valida,
    input  logic [2:0] tipo,
    input  logic [3:0] X1,
    input  logic [3:0] Y1,
    input  logic       direcao,
    input  logic [2:0] orientacao,
    input  logic       jogador,
    input  logic       limpa,
    output logic       conflito,
    output logic       ocupado,
    output logic       pronto,
    input  logic       rd_jogador,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       rd_ocupada,
    output logic [4:0] celulas_j0,
    output logic [4:0] celulas_j1
);

    localparam int         IDX_W = $clog2(N_CEL);
    localparam logic [4:0] LADO  = 5'(N_LADO);

    estado_t estado, estado_prox;

    logic             valida_q;
    logic             rise, fall;

    // Copies of the request taken on the rising edge of valida.
    logic [2:0]       tipo_q;
    logic [3:0]       x1_q, y1_q;
    logic             direcao_q;
    logic [2:0]       orientacao_q;
    logic             jogador_q;

    logic [2:0]       k;
    logic [2:0]       dx, dy, len;
    logic             tipo_valido;
    logic             ultima;

    logic [4:0]       x_cel, y_cel;
    logic [IDX_W-1:0] idx_cel;
    logic             fora_cel, ocupada_cel, conflito_cel;

    logic             rd_dentro;
    logic [IDX_W-1:0] rd_idx;

    logic [N_CEL-1:0] tab_j0, tab_j1;

    assign rise = valida & ~valida_q;
    assign fall = ~valida & valida_q;

    gerador_celulas u_gerador (
        .tipo        (tipo_q),
        .direcao     (direcao_q),
        .orientacao  (orientacao_q),
        .k           (k),
        .dx          (dx),
        .dy          (dy),
        .len         (len),
        .tipo_valido (tipo_valido)
    );

    // Absolute coordinates of cell k; five bits so 15 + 4 cannot wrap.
    assign x_cel  = {1'b0, x1_q} + {2'b00, dx};
    assign y_cel  = {1'b0, y1_q} + {2'b00, dy};
    assign ultima = (k == (len - 3'd1));

    // A zero origin is rejected outright even when the shape offset would
    // carry the first cell back onto the board.
    assign fora_cel = !tipo_valido || (x1_q == 4'd0) || (y1_q == 4'd0) ||
                      (x_cel == 5'd0) || (x_cel > LADO) ||
                      (y_cel == 5'd0) || (y_cel > LADO);

    // Linear cell index; only meaningful when the cell is on the board.
    assign idx_cel = IDX_W'((int'(y_cel) - 1) * N_LADO + (int'(x_cel) - 1));

    assign ocupada_cel  = !fora_cel && (jogador_q ? tab_j1[idx_cel] : tab_j0[idx_cel]);
    assign conflito_cel = fora_cel || ocupada_cel;

    // Read port for the game-execution stage; masked when off the board.
    assign rd_dentro  = (rd_x != 4'd0) && ({1'b0, rd_x} <= LADO) &&
                        (rd_y != 4'd0) && ({1'b0, rd_y} <= LADO);
    assign rd_idx     = IDX_W'((int'(rd_y) - 1) * N_LADO + (int'(rd_x) - 1));
    assign rd_ocupada = rd_dentro && (rd_jogador ? tab_j1[rd_idx] : tab_j0[rd_idx]);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic and the state-decoded busy/ready flags.
    always_comb begin
        estado_prox = estado;
        ocupado     = 1'b0;
        pronto      = 1'b0;
        case (estado)
            IDLE: begin
                if (rise) estado_prox = CHECK;
            end
            CHECK: begin
                ocupado = 1'b1;
                if (fall) begin
                    estado_prox = IDLE;
                end else if (conflito_cel || ultima) begin
                    estado_prox = RESULT;
                end
            end
            RESULT: begin
                pronto = 1'b1;
                if (fall) estado_prox = conflito ? IDLE : WRITE;
            end
            WRITE: begin
                ocupado = 1'b1;
                if (ultima) estado_prox = IDLE;
            end
            default: estado_prox = IDLE;
        endcase
    end

    // Datapath: edge detector, request latches, cell counter, result flag,
    // boards and per-player counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the boards are flop vectors, not RAM, and must come up
            // empty, so they are cleared by the reset like any other state.
            valida_q     <= 1'b0;
            tipo_q       <= 3'd0;
            x1_q         <= 4'd0;
            y1_q         <= 4'd0;
            direcao_q    <= 1'b0;
            orientacao_q <= 3'd0;
            jogador_q    <= 1'b0;
            k            <= 3'd0;
            conflito     <= 1'b0;
            tab_j0       <= '0;
            tab_j1       <= '0;
            celulas_j0   <= 5'd0;
            celulas_j1   <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the register values from before this edge.
            valida_q <= valida;
            case (estado)
                IDLE: begin
                    if (rise) begin
                        tipo_q       <= tipo;
                        x1_q         <= X1;
                        y1_q         <= Y1;
                        direcao_q    <= direcao;
                        orientacao_q <= orientacao;
                        jogador_q    <= jogador;
                        k            <= 3'd0;
                        conflito     <= 1'b1;
                    end else if (limpa) begin
                        tab_j0     <= '0;
                        tab_j1     <= '0;
                        celulas_j0 <= 5'd0;
                        celulas_j1 <= 5'd0;
                    end
                end
                CHECK: begin
                    if (fall) begin
                        conflito <= 1'b1;
                    end else if (!conflito_cel) begin
                        if (ultima) conflito <= 1'b0;
                        else        k        <= k + 3'd1;
                    end
                end
                RESULT: begin
                    if (fall && !conflito) k <= 3'd0;
                end
                WRITE: begin
                    if (jogador_q) begin
                        tab_j1[idx_cel] <= 1'b1;
                        celulas_j1      <= incr_sat(celulas_j1);
                    end else begin
                        tab_j0[idx_cel] <= 1'b1;
                        celulas_j0      <= incr_sat(celulas_j0);
                    end
                    k <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_validador_pecas.sv
// Directed bench for validador_pecas: a table of placements applied in order
// on a growing board, then hand-written abort, reset-mid-write and clear
// sequences, plus read-port checks.
module tb_validador_pecas;

    logic       clk = 1'b0;
    logic       reset;
    logic       valida;
    logic [2:0] tipo;
    logic [3:0] X1, Y1;
    logic       direcao;
    logic [2:0] orientacao;
    logic       jogador;
    logic       limpa;
    logic       conflito, ocupado, pronto;
    logic       rd_jogador;
    logic [3:0] rd_x, rd_y;
    logic       rd_ocupada;
    logic [4:0] celulas_j0, celulas_j1;

    int checks = 0;
    int errors = 0;

    validador_pecas dut (
        .clk        (clk),
        .reset      (reset),
        .valida     (valida),
        .tipo       (tipo),
        .X1         (X1),
        .Y1         (Y1),
        .direcao    (direcao),
        .orientacao (orientacao),
        .jogador    (jogador),
        .limpa      (limpa),
        .conflito   (conflito),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .rd_jogador (rd_jogador),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_ocupada (rd_ocupada),
        .celulas_j0 (celulas_j0),
        .celulas_j1 (celulas_j1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       jog;
        logic [2:0] tipo;
        logic [3:0] x;
        logic [3:0] y;
        logic       dir;
        logic [2:0] ori;
        int         lat;   // edges from the rise sample edge until pronto
        logic       conf;
        int         wr;    // WRITE cycles after the fall
        int         c0;
        int         c1;
    } vetor_t;

    vetor_t tab[11];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic ler_check(input string nome, input logic j, input int x, input int y, input logic esp);
        rd_jogador = j;
        rd_x       = 4'(x);
        rd_y       = 4'(y);
        #1;
        check(nome, rd_ocupada, esp);
    endtask

    // One full placement: rise, scramble inputs, wait for pronto, fall,
    // wait for the write phase to finish, check counts.
    task automatic colocar(input vetor_t v, input string nome);
        int arestas;
        int n;
        @(negedge clk);
        jogador    = v.jog;
        tipo       = v.tipo;
        X1         = v.x;
        Y1         = v.y;
        direcao    = v.dir;
        orientacao = v.ori;
        valida     = 1'b1;
        @(posedge clk);
        arestas = 1;
        @(negedge clk);
        // Later input changes must not affect the check.
        tipo       = 3'd0;
        X1         = 4'd1;
        Y1         = 4'd1;
        direcao    = ~v.dir;
        jogador    = ~v.jog;
        orientacao = 3'd1;
        check({nome, ".ocupado_check"}, ocupado, 1'b1);
        while (!pronto && arestas < 20) begin
            @(posedge clk);
            arestas++;
            @(negedge clk);
        end
        check({nome, ".latencia"}, arestas, v.lat);
        check({nome, ".conflito"}, conflito, v.conf);
        check({nome, ".ocupado_result"}, ocupado, 1'b0);
        valida = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (ocupado && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({nome, ".ciclos_escrita"}, n, v.wr);
        check({nome, ".pronto_idle"}, pronto, 1'b0);
        check({nome, ".celulas_j0"}, celulas_j0, v.c0);
        check({nome, ".celulas_j1"}, celulas_j1, v.c1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        //          jog  tipo  x      y      dir   ori   lat conf wr c0 c1
        tab[0]  = '{1'b0, 3'd4, 4'd2, 4'd3, 1'b0, 3'd0, 6, 1'b0, 5, 5, 0};   // porta-avioes
        tab[1]  = '{1'b0, 3'd1, 4'd4, 4'd2, 1'b1, 3'd0, 3, 1'b1, 0, 5, 0};   // overlap at (4,3)
        tab[2]  = '{1'b0, 3'd3, 4'd6, 4'd1, 1'b0, 3'd0, 5, 1'b1, 0, 5, 0};   // x=9 off board
        tab[3]  = '{1'b0, 3'd0, 4'd0, 4'd5, 1'b0, 3'd0, 2, 1'b1, 0, 5, 0};   // X1=0
        tab[4]  = '{1'b1, 3'd2, 4'd1, 4'd1, 1'b0, 3'd4, 4, 1'b0, 3, 5, 3};   // hidroaviao ori 4
        tab[5]  = '{1'b0, 3'd5, 4'd1, 4'd1, 1'b0, 3'd0, 2, 1'b1, 0, 5, 3};   // illegal tipo
        tab[6]  = '{1'b0, 3'd0, 4'd8, 4'd8, 1'b0, 3'd0, 2, 1'b0, 1, 6, 3};   // corner cell
        tab[7]  = '{1'b1, 3'd2, 4'd7, 4'd6, 1'b0, 3'd3, 4, 1'b0, 3, 6, 6};   // ori 3 -> (8,6)(7,7)(8,8)
        tab[8]  = '{1'b0, 3'd1, 4'd2, 4'd3, 1'b0, 3'd0, 2, 1'b1, 0, 6, 6};   // overlap on first cell
        tab[9]  = '{1'b1, 3'd2, 4'd5, 4'd5, 1'b0, 3'd2, 4, 1'b0, 3, 6, 9};   // ori 2 -> (5,5)(6,6)(5,7)
        tab[10] = '{1'b1, 3'd2, 4'd1, 4'd7, 1'b0, 3'd1, 4, 1'b0, 3, 6, 12};  // ori 1 -> (1,8)(2,7)(3,8)

        reset      = 1'b0;
        valida     = 1'b0;
        tipo       = 3'd0;
        X1         = 4'd0;
        Y1         = 4'd0;
        direcao    = 1'b0;
        orientacao = 3'd0;
        jogador    = 1'b0;
        limpa      = 1'b0;
        rd_jogador = 1'b0;
        rd_x       = 4'd1;
        rd_y       = 4'd1;

        repeat (2) @(negedge clk);
        check("reset.conflito", conflito, 1'b0);
        check("reset.ocupado", ocupado, 1'b0);
        check("reset.pronto", pronto, 1'b0);
        check("reset.celulas_j0", celulas_j0, 5'd0);
        check("reset.celulas_j1", celulas_j1, 5'd0);
        ler_check("reset.celula", 1'b0, 1, 1, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            colocar(tab[i], $sformatf("vetor%0d", i));
        end

        // Board contents after the table.
        @(negedge clk);
        for (int x = 2; x <= 6; x++) ler_check($sformatf("j0.porta_avioes_%0d", x), 1'b0, x, 3, 1'b1);
        ler_check("j0.antes_linha", 1'b0, 1, 3, 1'b0);
        ler_check("j0.depois_linha", 1'b0, 7, 3, 1'b0);
        ler_check("j0.cruzador_descartado", 1'b0, 4, 2, 1'b0);
        ler_check("j0.canto", 1'b0, 8, 8, 1'b1);
        ler_check("j1.hidro_a", 1'b1, 1, 1, 1'b1);
        ler_check("j1.hidro_b", 1'b1, 2, 2, 1'b1);
        ler_check("j1.hidro_c", 1'b1, 3, 1, 1'b1);
        ler_check("j1.hidro_vazio", 1'b1, 2, 1, 1'b0);
        ler_check("j0.intocado", 1'b0, 1, 1, 1'b0);
        ler_check("j1.ori3", 1'b1, 8, 6, 1'b1);
        ler_check("j1.ori2", 1'b1, 5, 7, 1'b1);
        ler_check("j1.ori1", 1'b1, 2, 7, 1'b1);
        ler_check("rd.x_zero", 1'b0, 0, 3, 1'b0);
        ler_check("rd.x_nove", 1'b0, 9, 2, 1'b0);

        // Abort: valida falls during the second CHECK cycle.
        @(negedge clk);
        jogador = 1'b0; tipo = 3'd4; X1 = 4'd1; Y1 = 4'd5; direcao = 1'b0;
        valida  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        valida = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("aborto.ocupado", ocupado, 1'b0);
        check("aborto.pronto", pronto, 1'b0);
        check("aborto.conflito", conflito, 1'b1);
        check("aborto.celulas_j0", celulas_j0, 5'd6);
        ler_check("aborto.sem_escrita", 1'b0, 1, 5, 1'b0);
        colocar('{1'b0, 3'd0, 4'd1, 4'd5, 1'b0, 3'd0, 2, 1'b0, 1, 7, 12}, "pos_aborto");
        ler_check("pos_aborto.celula", 1'b0, 1, 5, 1'b1);

        // Reset during the third WRITE cycle of a porta-avioes on j1 row 4.
        @(negedge clk);
        jogador = 1'b1; tipo = 3'd4; X1 = 4'd1; Y1 = 4'd4; direcao = 1'b0;
        valida  = 1'b1;
        n = 0;
        @(posedge clk);
        @(negedge clk);
        while (!pronto && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("rst_escrita.conflito", conflito, 1'b0);
        valida = 1'b0;
        @(posedge clk);   // RESULT -> WRITE
        @(posedge clk);   // first cell
        @(posedge clk);   // second cell
        @(negedge clk);
        check("rst_escrita.parcial", celulas_j1, 5'd14);
        reset = 1'b0;
        #1;
        check("rst_escrita.celulas_j0", celulas_j0, 5'd0);
        check("rst_escrita.celulas_j1", celulas_j1, 5'd0);
        check("rst_escrita.ocupado", ocupado, 1'b0);
        check("rst_escrita.pronto", pronto, 1'b0);
        check("rst_escrita.conflito", conflito, 1'b0);
        ler_check("rst_escrita.parcial_limpo", 1'b1, 1, 4, 1'b0);
        ler_check("rst_escrita.j0_limpo", 1'b0, 2, 3, 1'b0);
        ler_check("rst_escrita.j1_limpo", 1'b1, 8, 8, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // limpa in IDLE clears a populated board.
        colocar('{1'b0, 3'd1, 4'd3, 4'd3, 1'b0, 3'd0, 3, 1'b0, 2, 2, 0}, "antes_limpa");
        ler_check("antes_limpa.celula", 1'b0, 4, 3, 1'b1);
        @(negedge clk);
        limpa = 1'b1;
        @(negedge clk);
        limpa = 1'b0;
        check("limpa.celulas_j0", celulas_j0, 5'd0);
        ler_check("limpa.celula", 1'b0, 4, 3, 1'b0);
        colocar('{1'b0, 3'd1, 4'd3, 4'd3, 1'b0, 3'd0, 3, 1'b0, 2, 2, 0}, "pos_limpa");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/validador_pecas.md
Name: validador_pecas

Overview:
- Downstream stage of the piece-placement FSM; consumes valida, tipo, X1/Y1, direcao, orientacao and jogador, and returns conflito.
- Holds both players' 8x8 occupancy boards.
- Checks a proposed piece cell by cell for out-of-board and overlap, and commits the cells when the placement FSM leaves the check with no conflict.
- Exposes a read port and per-player cell counts for the game-execution stage.

Parameters:
- N_LADO, 8, board side; coordinates are 1..N_LADO and 0 is invalid (no switch selected). Must be <=15.
- N_CEL, 64, cells per board (N_LADO*N_LADO).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- valida  in  1  level from placement FSM; rising edge starts a check, falling edge commits or discards
- tipo  in  3  0 submarino, 1 cruzador, 2 hidroaviao, 3 encouracado, 4 porta-avioes; 5..7 illegal
- X1, Y1  in  4 each  origin coordinates, 1..N_LADO
- direcao  in  1  0 horizontal (+X), 1 vertical (+Y); ignored for hidroaviao
- orientacao  in  3  hidroaviao shape 0..3; 4 is treated as 0; ignored for other types
- jogador  in  1  target board
- limpa  in  1  synchronous clear of both boards and counts while IDLE
- conflito  out  1  check result
- ocupado  out  1  high while CHECK or WRITE
- pronto  out  1  high in RESULT (result valid)
- rd_jogador  in  1  read-port board select
- rd_x, rd_y  in  4 each  read-port coordinates
- rd_ocupada  out  1  combinational cell state; 0 when coordinates are out of range
- celulas_j0, celulas_j1  out  5 each  occupied-cell count per player (full fleet = 24)

Behaviour:
- Reset values: boards 0, counts 0, conflito 0, ocupado 0, pronto 0, state IDLE, valida_q 0.
- Edge detection: valida_q <= valida every cycle. rise = valida & ~valida_q; fall = ~valida & valida_q.
- Piece shapes, as offsets (dx, dy) from (X1, Y1):
  - Line pieces have lengths 1, 2, 4, 5 for tipo 0, 1, 3, 4. Cell k is (k,0) if direcao=0, else (0,k).
  - Hidroaviao has 3 cells. orientacao 0: (0,0)(1,1)(2,0). 1: (0,1)(1,0)(2,1). 2: (0,0)(1,1)(0,2). 3: (1,0)(0,1)(1,2).
- Cell index = (y-1)*N_LADO + (x-1).
- FSM states: IDLE, CHECK, RESULT, WRITE.
- IDLE:
  - On rise: latch all inputs, set k=0, conflito<=1 (pessimistic), ocupado<=1, go to CHECK.
  - On limpa with no rise: clear boards and counts.
- CHECK (one cell per cycle, cell k):
  - If the cell is out of range (x or y equal to 0 or greater than N_LADO) or already occupied: conflito stays 1, go to RESULT.
  - Else if k==len-1: conflito<=0, go to RESULT.
  - Else k<=k+1.
  - Result latency: len+1 clk edges after the rise sample edge in the no-conflict case; fewer on an early conflict.
  - Illegal tipo or X1/Y1 = 0 gives conflict on the first CHECK cycle.
- RESULT: pronto=1, ocupado=0, conflito held.
  - fall with conflito=0: k<=0, ocupado<=1, go to WRITE.
  - fall with conflito=1: go to IDLE, board unchanged.
  - rise while in RESULT is impossible (valida must fall first); ignore it.
- WRITE: set the bit of cell k on the latched jogador's board, one cell per cycle. Increment that player's count. At k==len-1 go to IDLE. conflito is held through WRITE.
- fall during CHECK (abort): go to IDLE, pronto 0, no write, conflito<=1.
- Inputs changing after the rise have no effect, because the check uses latched copies.
- Asynchronous reset mid-CHECK or mid-WRITE clears everything, including a partially written piece.
- The read port is unaffected by the FSM; it reflects a write the cycle after it occurs.
- Counts saturate at 31. Never-reached guard only.

Decomposition:
- Shared package pecas_pkg holds:
  - tipo encodings and the comprimento table.
  - N_LADO default.
  - FSM state encoding.
- One natural sub-module, gerador_celulas: combinational. Inputs tipo, direcao, orientacao, k. Outputs dx, dy, len and tipo_valido. It is used by both CHECK and WRITE.

Test Plan:
- Porta-avioes, jogador 0, (2,3), direcao 0 → valida rises. pronto after 6 edges, conflito=0. valida falls → 5 WRITE cycles. Cells (2..6,3) read back 1; celulas_j0=5.
- Same board, cruzador at (4,2), direcao 1 → overlap at (4,3). conflito=1, pronto on the 2nd CHECK cycle. Fall → board and count unchanged.
- Encouracado at (6,1), direcao 0 → x=9 is out of range, conflito=1. Also X1=0 → conflito=1 on the first CHECK cycle.
- Hidroaviao, orientacao 4, jogador 1, (1,1) → cells (1,1)(2,2)(3,1) written. celulas_j1=3; jogador 0 board untouched.
- valida falls in the 2nd CHECK cycle → IDLE, no write, conflito=1. A following valid check behaves normally.
- reset asserted during the 3rd WRITE cycle → all boards 0, counts 0, outputs at reset values. limpa in IDLE clears a populated board.
